spi_instruction_receiver: RTL and testbench
===========================================

Name: spi_instruction_receiver

Overview:
- SPI peripheral (mode 0, MSB first) that deserializes instruction frames from an external host and issues them to the execution unit.
- Each frame carries a 4-bit opcode followed by an 8-bit operand.
- While the frame is clocked in, the block shifts the previous CPU output (result_in) back to the host on spi_miso.
- Sits between the chip pins and the execution unit's opcode/operand/start inputs. All SPI inputs are oversampled in the clk domain.

Parameters:
- INPUT_DATA_WIDTH, 4, opcode width; operand is 2x this width.
- OUTPUT_DATA_WIDTH, 8, width of result_in shifted out on MISO.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk/cs_n/mosi (minimum 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- spi_sclk  input  1  SPI clock from host; must be at most clk/4.
- spi_cs_n  input  1  active-low chip select.
- spi_mosi  input  1  serial data in.
- spi_miso  output  1  serial data out.
- result_in  input  OUTPUT_DATA_WIDTH  CPU output value, captured at frame start.
- opcode  output  INPUT_DATA_WIDTH  last accepted opcode; held between frames.
- operand  output  2*INPUT_DATA_WIDTH  last accepted operand; held between frames.
- instr_valid  output  1  one-clk pulse when a new opcode/operand is presented.
- frame_error  output  1  one-clk pulse when a frame is aborted.
- busy  output  1  high while a frame is in progress (SHIFT state).

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - opcode=0, operand=0, instr_valid=0, frame_error=0, busy=0, spi_miso=0.
  - bit counter=0, state=WAIT_CS.
- Input conditioning:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk and cs_n: previous-value register plus compare.
  - mosi is sampled from the synchronized value in the same cycle the synchronized sclk rise is detected.
- FRAME_BITS = 3*INPUT_DATA_WIDTH (12).
- WAIT_CS state:
  - Ignore all sclk edges.
  - Go to IDLE once synchronized cs_n=1.
  - This is the state after reset, and prevents acceptance of a frame already in progress at reset release.
- IDLE state:
  - spi_miso=0.
  - On synchronized cs_n fall: go to SHIFT, clear bit counter, load tx shift register with result_in.
- SHIFT state:
  - busy=1.
  - spi_miso = tx_sr MSB while bit counter < OUTPUT_DATA_WIDTH, else 0.
  - On sclk rise: rx_sr <= {rx_sr, mosi}; counter++.
  - On sclk fall: tx_sr shifts left with 0 fill. The first MSB is valid before the first rising edge (mode 0).
  - When the counter reaches FRAME_BITS on a rise, go to DONE.
  - cs_n rise before FRAME_BITS: frame_error pulses 1 clk, no instr_valid, opcode/operand unchanged, go to IDLE.
- DONE state (one cycle):
  - opcode <= rx_sr[11:8], operand <= rx_sr[7:0], instr_valid=1 for exactly this cycle.
  - Then go to WAIT_CS. Extra sclk edges before cs_n rises are ignored and are not an error.
- Latency: instr_valid is asserted 1 clk after the clk cycle that detects the 12th synchronized sclk rise.
- Simultaneous events: cs_n rise and the 12th sclk rise detected in the same clk → frame accepted (the 12th bit wins).
- Reset mid-frame: outputs return to reset values; the partial frame is discarded with no frame_error.

Optional Feature:
- Macro SPI_PARITY_CHECK_EN.
- Defined:
  - Frame is FRAME_BITS+1 bits; the final bit is even parity over the 12 data bits.
  - DONE checks parity. On mismatch: frame_error pulse, no instr_valid, opcode/operand held.
  - cs_n rise before 13 bits → frame_error.
- Undefined: 12-bit frames, no parity logic synthesized.

Decomposition:
- Shared package spi_pkg:
  - FRAME_BITS constant.
  - State encoding WAIT_CS, IDLE, SHIFT, DONE (2-bit localparams).
  - SPI mode constant (0).
- One sub-module spi_edge_sync:
  - Parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs.
  - Instantiated for sclk and cs_n; mosi uses a plain synchronizer from the same module.

Test Plan:
- Basic frame:
  - Stimulus: reset, cs_n high, result_in=0xA5; host sends 12 bits 0x3_7C at clk/8.
  - Required response: opcode=3, operand=0x7C, a single instr_valid pulse, frame_error never asserted.
- MISO readback:
  - Stimulus: result_in=0xC3 at cs_n fall, then result_in changed to 0xFF mid-frame.
  - Required response: host samples 1,1,0,0,0,0,1,1 on rising edges 1-8, then 0 for bits 9-12.
- Aborted frame:
  - Stimulus: cs_n raised after 7 bits.
  - Required response: frame_error pulses once, instr_valid=0, opcode/operand retain the prior frame values.
- Over-clocked frame:
  - Stimulus: 16 sclk pulses sending 0x5_A1 then 0xF.
  - Required response: opcode=5, operand=0xA1, one instr_valid, no error.
- Reset mid-frame:
  - Stimulus: assert reset after 6 bits with cs_n still low, release reset, continue clocking.
  - Required response: no instr_valid until cs_n rises and a fresh 12-bit frame completes.
- Back-to-back frames:
  - Stimulus: 0x1_11 then 0x2_22, with 4 clk of cs_n high between them.
  - Required response: two instr_valid pulses with the correct values each. Under SPI_PARITY_CHECK_EN, a wrong parity bit on the second frame gives frame_error and opcode stays 1.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants for the SPI instruction receiver:
//   - FRAME_BITS : data bits per instruction frame (4-bit opcode + 8-bit operand)
//   - SPI_MODE   : clock polarity/phase mode implemented by the receiver (0)
//   - state_t and ST_* : 2-bit FSM state encoding
// No ports.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int INPUT_DATA_WIDTH_DEF = 4;
    localparam int FRAME_BITS           = 3 * INPUT_DATA_WIDTH_DEF;
    localparam int SPI_MODE             = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_CS = 2'd0;  // wait for a clean deselect
    localparam state_t ST_IDLE    = 2'd1;  // deselected, waiting for cs_n fall
    localparam state_t ST_SHIFT   = 2'd2;  // frame in progress
    localparam state_t ST_DONE    = 2'd3;  // one-cycle frame commit

endpackage

// File: rtl/spi_edge_sync.sv
// -----------------------------------------------------------------------------
// spi_edge_sync
// Multi-flop synchronizer for one asynchronous pin, with single-cycle rise and
// fall pulses derived from the synchronized level (previous-value compare).
// Also used as a plain synchronizer when the edge pulses are not needed.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth, minimum 2
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset (all flops clear to 0)
//   din      in  asynchronous pin
//   sync_out out synchronized level
//   rise     out one-clk pulse on a 0->1 transition of sync_out
//   fall     out one-clk pulse on a 1->0 transition of sync_out
// -----------------------------------------------------------------------------
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   prev;

    // NOTE: synchronizer flops are reset so edge detection starts from a known
    // level; clearing to 0 makes chip select look "selected" after reset, so
    // the receiver waits for a genuine deselect before accepting a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_ff <= '0;
            prev    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every stage samples the value
            // its neighbour held before this edge, forming a true shift chain.
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
            prev    <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_ff[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev;
    assign fall     = ~sync_out & prev;

endmodule

// File: rtl/spi_instruction_receiver.sv
// -----------------------------------------------------------------------------
// spi_instruction_receiver
// SPI mode-0 peripheral, MSB first. Deserializes {opcode, operand} frames from
// the host and presents them to the execution unit with a one-clk instr_valid
// pulse. During the frame, the result_in value captured at cs_n fall is
// shifted back to the host on spi_miso. All SPI pins are oversampled in clk.
//
// Optional feature: define SPI_PARITY_CHECK_EN to append one even-parity bit
// to each frame; a parity mismatch raises frame_error instead of instr_valid.
//
// Parameters:
//   INPUT_DATA_WIDTH  : opcode width (operand is twice this)
//   OUTPUT_DATA_WIDTH : width of result_in shifted out on spi_miso
//   SYNC_STAGES       : synchronizer depth on sclk/cs_n/mosi (minimum 2)
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   spi_sclk     in   SPI clock from host (at most clk/4)
//   spi_cs_n     in   active-low chip select
//   spi_mosi     in   serial data in
//   spi_miso     out  serial data out
//   result_in    in   CPU result, captured at frame start
//   opcode       out  last accepted opcode, held between frames
//   operand      out  last accepted operand, held between frames
//   instr_valid  out  one-clk pulse when a new instruction is accepted
//   frame_error  out  one-clk pulse when a frame is aborted or rejected
//   busy         out  high while a frame is being shifted
// -----------------------------------------------------------------------------
module spi_instruction_receiver
    import spi_pkg::*;
#(
    parameter int INPUT_DATA_WIDTH  = FRAME_BITS / 3,
    parameter int OUTPUT_DATA_WIDTH = 8,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_sclk,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    input  logic [OUTPUT_DATA_WIDTH-1:0]  result_in,
    output logic [INPUT_DATA_WIDTH-1:0]   opcode,
    output logic [2*INPUT_DATA_WIDTH-1:0] operand,
    output logic                          instr_valid,
    output logic                          frame_error,
    output logic                          busy
);

    localparam int DATA_BITS = 3 * INPUT_DATA_WIDTH;
`ifdef SPI_PARITY_CHECK_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int FRAME_LEN = DATA_BITS + PAR_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] MISO_BITS = CNT_W'(OUTPUT_DATA_WIDTH);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk      (clk),
        .reset    (reset),
        .din      (spi_sclk),
        .sync_out (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk      (clk),
        .reset    (reset),
        .din      (spi_cs_n),
        .sync_out (cs_sync),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // Same depth as sclk, so mosi_sync on the rise-detect cycle is the bit
    // the host presented at its sclk rising edge.
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk      (clk),
        .reset    (reset),
        .din      (spi_mosi),
        .sync_out (mosi_sync),
        .rise     (mosi_rise_unused),
        .fall     (mosi_fall_unused)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                        state, next_state;
    logic [CNT_W-1:0]              bit_cnt;
    logic [FRAME_LEN-1:0]          rx_sr;
    logic [OUTPUT_DATA_WIDTH-1:0]  tx_sr;
    logic                          frame_complete;
    logic                          frame_ok;

    // The last bit wins over a simultaneous cs_n rise.
    assign frame_complete = (state == ST_SHIFT) && sclk_rise && (bit_cnt == LAST_BIT);

`ifdef SPI_PARITY_CHECK_EN
    // Even parity over data bits plus parity bit must reduce to 0.
    assign frame_ok = ~(^rx_sr);
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_WAIT_CS;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path assigns next_state and
        // no latch is inferred.
        next_state = state;
        case (state)
            ST_WAIT_CS: if (cs_sync) next_state = ST_IDLE;
            ST_IDLE:    if (cs_fall) next_state = ST_SHIFT;
            ST_SHIFT: begin
                if (frame_complete)  next_state = ST_DONE;
                else if (cs_rise)    next_state = ST_IDLE;
            end
            ST_DONE:    next_state = ST_WAIT_CS;
            default:    next_state = ST_WAIT_CS;
        endcase
    end

    always_comb begin
        busy        = (state == ST_SHIFT);
        spi_miso    = ((state == ST_SHIFT) && (bit_cnt < MISO_BITS)) ?
                      tx_sr[OUTPUT_DATA_WIDTH-1] : 1'b0;
        instr_valid = (state == ST_DONE) && frame_ok;
        frame_error = ((state == ST_SHIFT) && cs_rise && !frame_complete) ||
                      ((state == ST_DONE) && !frame_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            opcode  <= '0;
            operand <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        bit_cnt <= '0;
                        tx_sr   <= result_in;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_sr   <= {rx_sr[FRAME_LEN-2:0], mosi_sync};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    // Mode 0: the host samples on rise, so advance MISO on fall.
                    if (sclk_fall) begin
                        tx_sr <= {tx_sr[OUTPUT_DATA_WIDTH-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (frame_ok) begin
                        opcode  <= rx_sr[PAR_BITS + 2*INPUT_DATA_WIDTH +: INPUT_DATA_WIDTH];
                        operand <= rx_sr[PAR_BITS +: 2*INPUT_DATA_WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_instruction_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_instruction_receiver
// Directed, table-driven bench for spi_instruction_receiver. The host model
// drives SPI mode 0 at clk/8 and samples spi_miso just before each sclk rise.
// Define SPI_PARITY_CHECK_EN to build both bench and design with parity.
// -----------------------------------------------------------------------------
module tb_spi_instruction_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] result_in;
    logic [3:0] opcode;
    logic [7:0] operand;
    logic       instr_valid;
    logic       frame_error;
    logic       busy;

    always #5 clk = ~clk;

    spi_instruction_receiver #(
        .INPUT_DATA_WIDTH  (4),
        .OUTPUT_DATA_WIDTH (8),
        .SYNC_STAGES       (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .result_in   (result_in),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    // Pulse counters: one count per clk cycle the output is high.
    int iv_cnt = 0;
    int fe_cnt = 0;
    always @(negedge clk) begin
        if (instr_valid) iv_cnt++;
        if (frame_error) fe_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] miso_cap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One host bit: present mosi, sample miso, rise, hold, fall.
    task automatic send_bit(input logic b, input bit raise_cs, output logic m);
        spi_mosi = b;
        wait_clk(4);
        m        = spi_miso;
        spi_sclk = 1'b1;
        if (raise_cs) spi_cs_n = 1'b1;
        wait_clk(4);
        spi_sclk = 1'b0;
    endtask

    // Build the on-wire bit vector for 12 data bits (plus parity if enabled).
    task automatic build(input logic [11:0] data, input bit bad_par,
                         output logic [19:0] v, output int len);
`ifdef SPI_PARITY_CHECK_EN
        v   = {7'd0, data, (^data) ^ bad_par};
        len = 13;
`else
        v   = {8'd0, data};
        len = 12;
`endif
    endtask

    task automatic run_frame(input logic [19:0] v, input int len, input bit last_with_cs,
                             input logic [7:0] res_mid, input int gap);
        logic m;
        spi_cs_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < len; i++) begin
            send_bit(v[len-1-i], last_with_cs && (i == len - 1), m);
            if (i < 12) miso_cap[11-i] = m;
            if (i == 0) result_in = res_mid;
        end
        wait_clk(2);
        spi_cs_n = 1'b1;
        wait_clk(gap);
    endtask

    typedef struct {
        string      name;
        logic [11:0] data;
        logic [7:0] res_start;
        logic [7:0] res_mid;
        int         n_extra;
        logic [3:0] extra;
        logic [3:0] exp_op;
        logic [7:0] exp_operand;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] v;
        int          len;
        int          iv0, fe0;
        logic        m;

        vecs[0] = '{"basic",     12'h37C, 8'hA5, 8'hA5, 0, 4'h0, 4'h3, 8'h7C};
        vecs[1] = '{"miso",      12'h0F0, 8'hC3, 8'hFF, 0, 4'h0, 4'h0, 8'hF0};
        vecs[2] = '{"overclock", 12'h5A1, 8'h00, 8'h00, 4, 4'hF, 4'h5, 8'hA1};
        vecs[3] = '{"mixed",     12'hE01, 8'h81, 8'h3C, 0, 4'h0, 4'hE, 8'h01};

        // ---------------- reset values ----------------
        reset     = 1'b1;
        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        result_in = 8'h00;
        wait_clk(3);
        check("rst_opcode",      32'(opcode),      32'h0);
        check("rst_operand",     32'(operand),     32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_frame_error", 32'(frame_error), 32'h0);
        check("rst_busy",        32'(busy),        32'h0);
        check("rst_miso",        32'(spi_miso),    32'h0);
        reset = 1'b0;
        wait_clk(4);

        // ---------------- table-driven frames ----------------
        for (int k = 0; k < 4; k++) begin
            result_in = vecs[k].res_start;
            iv0 = iv_cnt;
            fe0 = fe_cnt;
            build(vecs[k].data, 1'b0, v, len);
            if (vecs[k].n_extra > 0) begin
                v   = (v << vecs[k].n_extra) | 20'(vecs[k].extra);
                len = len + vecs[k].n_extra;
            end
            run_frame(v, len, 1'b0, vecs[k].res_mid, 8);
            check({vecs[k].name, "_opcode"},  32'(opcode),      32'(vecs[k].exp_op));
            check({vecs[k].name, "_operand"}, 32'(operand),     32'(vecs[k].exp_operand));
            check({vecs[k].name, "_iv_cnt"},  32'(iv_cnt - iv0), 32'd1);
            check({vecs[k].name, "_fe_cnt"},  32'(fe_cnt - fe0), 32'd0);
            check({vecs[k].name, "_miso"},    32'(miso_cap),    32'({vecs[k].res_start, 4'h0}));
        end

        // ---------------- aborted frame after 7 bits ----------------
        iv0 = iv_cnt;
        fe0 = fe_cnt;
        run_frame(20'b0110011, 7, 1'b0, 8'h00, 8);
        check("abort_opcode",  32'(opcode),      32'hE);
        check("abort_operand", 32'(operand),     32'h01);
        check("abort_iv_cnt",  32'(iv_cnt - iv0), 32'd0);
        check("abort_fe_cnt",  32'(fe_cnt - fe0), 32'd1);

        // ---------------- cs_n rise together with the last bit ----------------
        iv0 = iv_cnt;
        fe0 = fe_cnt;
        build(12'h6B2, 1'b0, v, len);
        run_frame(v, len, 1'b1, 8'h00, 8);
        check("simul_opcode",  32'(opcode),      32'h6);
        check("simul_operand", 32'(operand),     32'hB2);
        check("simul_iv_cnt",  32'(iv_cnt - iv0), 32'd1);
        check("simul_fe_cnt",  32'(fe_cnt - fe0), 32'd0);

        // ---------------- reset mid-frame ----------------
        spi_cs_n = 1'b0;
        wait_clk(4);
        check("midrst_busy_before", 32'(busy), 32'h1);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, m);
        fe0 = fe_cnt;
        reset = 1'b1;
        wait_clk(2);
        check("midrst_opcode",  32'(opcode),  32'h0);
        check("midrst_operand", 32'(operand), 32'h0);
        reset = 1'b0;
        wait_clk(2);
        iv0 = iv_cnt;
        for (int i = 0; i < 12; i++) send_bit(1'b1, 1'b0, m);
        wait_clk(2);
        check("midrst_iv_cnt", 32'(iv_cnt - iv0), 32'd0);
        check("midrst_fe_cnt", 32'(fe_cnt - fe0), 32'd0);
        check("midrst_busy",   32'(busy),         32'h0);
        spi_cs_n = 1'b1;
        wait_clk(6);
        build(12'h456, 1'b0, v, len);
        run_frame(v, len, 1'b0, 8'h00, 8);
        check("midrst_fresh_opcode",  32'(opcode),      32'h4);
        check("midrst_fresh_operand", 32'(operand),     32'h56);
        check("midrst_fresh_iv_cnt",  32'(iv_cnt - iv0), 32'd1);

        // ---------------- back-to-back frames ----------------
        iv0 = iv_cnt;
        fe0 = fe_cnt;
        build(12'h111, 1'b0, v, len);
        run_frame(v, len, 1'b0, 8'h00, 4);
        check("b2b_first_opcode",  32'(opcode),  32'h1);
        check("b2b_first_operand", 32'(operand), 32'h11);
`ifdef SPI_PARITY_CHECK_EN
        build(12'h222, 1'b1, v, len);
        run_frame(v, len, 1'b0, 8'h00, 8);
        check("b2b_second_opcode",  32'(opcode),      32'h1);
        check("b2b_second_operand", 32'(operand),     32'h11);
        check("b2b_iv_cnt",         32'(iv_cnt - iv0), 32'd1);
        check("b2b_fe_cnt",         32'(fe_cnt - fe0), 32'd1);
`else
        build(12'h222, 1'b0, v, len);
        run_frame(v, len, 1'b0, 8'h00, 8);
        check("b2b_second_opcode",  32'(opcode),      32'h2);
        check("b2b_second_operand", 32'(operand),     32'h22);
        check("b2b_iv_cnt",         32'(iv_cnt - iv0), 32'd2);
        check("b2b_fe_cnt",         32'(fe_cnt - fe0), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
